// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transmit/receive path.
//   parity_e    - parity selection encoding (none / even / odd)
//   state_t     - transmitter FSM state type with legacy-compatible constants
//   byte_parity - XOR-reduce of one byte (even-parity bit)
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t PAR   = 3'd3;
    localparam state_t STOP  = 3'd4;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter shared by the UART transmitter and receiver.
//   CLK      in  system clock
//   CLR      in  asynchronous active-low reset
//   Enable   in  count while high; counter held at 0 while low
//   CLK_Baud out one-cycle strobe in the last cycle of each bit period
module uart_baud_gen #(
    parameter int BAUD_DIV = 434
) (
    input  logic CLK,
    input  logic CLR,
    input  logic Enable,
    output logic CLK_Baud
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            cnt <= '0;
        end else if (!Enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign CLK_Baud = Enable && (cnt == LAST);

endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: multi-byte UART transmitter. Accepts a DATA_W-bit word over
// Valid/Ready and sends it as DATA_W/8 back-to-back frames, LSB byte first.
//   CLK      in  system clock
//   CLR      in  asynchronous active-low reset
//   Data     in  word to send, sampled on accept
//   Valid    in  Data is valid
//   Ready    out block can accept a word
//   OUT_ser  out serial line, idle high
//   CLK_Baud out one-cycle strobe at the end of each transmitted bit
//   Busy     out a word is in flight
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BAUD_DIV  = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [DATA_W-1:0] Data,
    input  logic              Valid,
    output logic              Ready,
    output logic              OUT_ser,
    output logic              CLK_Baud,
    output logic              Busy
);

    localparam int   NBYTES  = DATA_W / 8;
    localparam int   BIW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam bit   HAS_PAR = (PARITY != int'(PAR_NONE));
    localparam logic PAR_INV = (PARITY == int'(PAR_ODD));
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [BIW-1:0] BYTE_LAST = BIW'(NBYTES - 1);

    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("uart_word_tx: DATA_W must be a multiple of 8 and >= 8");
    end
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_word_tx: BAUD_DIV must be >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_word_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_word_tx: STOP_BITS must be 1 or 2");
    end

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [BIW-1:0]    byte_idx;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic              par_bit;
    logic              tick;
    logic              baud_en;

    // Counter only runs outside IDLE, so every word starts phase-aligned to accept.
    assign baud_en = (state != IDLE);

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud (
        .CLK     (CLK),
        .CLR     (CLR),
        .Enable  (baud_en),
        .CLK_Baud(tick)
    );

    assign CLK_Baud = tick;

    // OUT_ser is loaded with the level of the *next* bit on the edge that ends
    // the current one; the word shifts right so the active byte sits in [7:0].
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            shreg    <= '0;
            byte_idx <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
            OUT_ser  <= 1'b1;
            Ready    <= 1'b1;
            Busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Valid && Ready) begin
                        shreg    <= Data;
                        byte_idx <= '0;
                        bit_cnt  <= '0;
                        stop_cnt <= 1'b0;
                        state    <= START;
                        OUT_ser  <= 1'b0;
                        Ready    <= 1'b0;
                        Busy     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        OUT_ser <= shreg[0];
                        par_bit <= byte_parity(shreg[7:0]) ^ PAR_INV;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        if (bit_cnt == 3'd7) begin
                            if (HAS_PAR) begin
                                state   <= PAR;
                                OUT_ser <= par_bit;
                            end else begin
                                state    <= STOP;
                                OUT_ser  <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            OUT_ser <= shreg[1];
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        state    <= STOP;
                        OUT_ser  <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            if (byte_idx == BYTE_LAST) begin
                                state   <= IDLE;
                                OUT_ser <= 1'b1;
                                Ready   <= 1'b1;
                                Busy    <= 1'b0;
                            end else begin
                                byte_idx <= byte_idx + BIW'(1);
                                state    <= START;
                                OUT_ser  <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    OUT_ser <= 1'b1;
                    Ready   <= 1'b1;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed bench for uart_word_tx. Four instances cover the
// frame formats of interest; a selector routes one instance's outputs to the
// checking tasks.
module tb_uart_word_tx;

    logic        CLK;
    logic        CLR;
    logic [3:0]  valid_v;
    logic [7:0]  d8a;
    logic [15:0] d16;
    logic [7:0]  d8c;
    logic [31:0] d32;
    logic [3:0]  ready_v, ser_v, baud_v, busy_v;

    logic [1:0]  sel;
    logic        ser_m, ready_m, busy_m, baud_m;
    logic        inc_en;

    int n_cmp;
    int n_fail;

    assign ser_m   = ser_v[sel];
    assign ready_m = ready_v[sel];
    assign busy_m  = busy_v[sel];
    assign baud_m  = baud_v[sel];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    uart_word_tx #(.DATA_W(8), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u_a (
        .CLK(CLK), .CLR(CLR), .Data(d8a), .Valid(valid_v[0]), .Ready(ready_v[0]),
        .OUT_ser(ser_v[0]), .CLK_Baud(baud_v[0]), .Busy(busy_v[0]));

    uart_word_tx #(.DATA_W(16), .BAUD_DIV(4), .PARITY(1), .STOP_BITS(1)) u_b (
        .CLK(CLK), .CLR(CLR), .Data(d16), .Valid(valid_v[1]), .Ready(ready_v[1]),
        .OUT_ser(ser_v[1]), .CLK_Baud(baud_v[1]), .Busy(busy_v[1]));

    uart_word_tx #(.DATA_W(8), .BAUD_DIV(4), .PARITY(2), .STOP_BITS(2)) u_c (
        .CLK(CLK), .CLR(CLR), .Data(d8c), .Valid(valid_v[2]), .Ready(ready_v[2]),
        .OUT_ser(ser_v[2]), .CLK_Baud(baud_v[2]), .Busy(busy_v[2]));

    uart_word_tx #(.DATA_W(32), .BAUD_DIV(4), .PARITY(0), .STOP_BITS(1)) u_d (
        .CLK(CLK), .CLR(CLR), .Data(d32), .Valid(valid_v[3]), .Ready(ready_v[3]),
        .OUT_ser(ser_v[3]), .CLK_Baud(baud_v[3]), .Busy(busy_v[3]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // 8N1 stream of a 32-bit word, first transmitted bit in the MSB of the result.
    function automatic logic [63:0] frame32(input logic [31:0] w);
        logic [63:0] f;
        logic [7:0]  b;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            b = w[8*i +: 8];
            f = {f[62:0], 1'b0};
            for (int j = 0; j < 8; j++) f = {f[62:0], b[j]};
            f = {f[62:0], 1'b1};
        end
        return f;
    endfunction

    // Expects Valid/Data already applied and the selected DUT idle; the next
    // rising edge is the accept edge t0. pat holds the bit stream MSB-first.
    task automatic run_frame(input logic [63:0] pat, input int nbits,
                             input bit keep_valid, input string tag);
        int pulses;
        int last;
        pulses = 0;
        last = nbits * 4 - 1;
        @(posedge CLK);
        #1;
        if (!keep_valid) valid_v[sel] = 1'b0;
        chk({tag, " ready_low_after_accept"}, 64'(ready_m), 64'd0);
        chk({tag, " busy_after_accept"}, 64'(busy_m), 64'd1);
        for (int c = 0; c <= last; c++) begin
            @(negedge CLK);
            chk($sformatf("%s ser_c%0d", tag, c), 64'(ser_m), 64'(pat[nbits - 1 - c / 4]));
            if (baud_m) pulses++;
            if (c == last) begin
                chk({tag, " baud_last_cycle"}, 64'(baud_m), 64'd1);
                chk({tag, " ready_before_end"}, 64'(ready_m), 64'd0);
            end
        end
        @(negedge CLK);
        chk({tag, " ready_at_end"}, 64'(ready_m), 64'd1);
        chk({tag, " busy_at_end"}, 64'(busy_m), 64'd0);
        chk({tag, " ser_idle_at_end"}, 64'(ser_m), 64'd1);
        chk({tag, " baud_pulses"}, 64'(pulses), 64'(nbits));
    endtask

    initial begin
        forever begin
            @(negedge CLK);
            if (inc_en) d32 = d32 + 32'd1;
        end
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        inc_en  = 1'b0;
        sel     = 2'd0;
        valid_v = '0;
        d8a     = '0;
        d16     = '0;
        d8c     = '0;
        d32     = '0;
        CLR     = 1'b0;

        repeat (3) @(negedge CLK);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #0;
            chk($sformatf("rst%0d ser", s), 64'(ser_m), 64'd1);
            chk($sformatf("rst%0d ready", s), 64'(ready_m), 64'd1);
            chk($sformatf("rst%0d busy", s), 64'(busy_m), 64'd0);
            chk($sformatf("rst%0d baud", s), 64'(baud_m), 64'd0);
        end
        CLR = 1'b1;
        repeat (2) @(negedge CLK);

        // 8N1, 0x03
        sel = 2'd0;
        d8a = 8'h03;
        valid_v[0] = 1'b1;
        run_frame(64'b0110000001, 10, 1'b0, "A");

        // 16-bit even parity, 0xA503: 0x03 then 0xA5, both parity 0
        sel = 2'd1;
        d16 = 16'hA503;
        valid_v[1] = 1'b1;
        run_frame(64'b0110000000101010010101, 22, 1'b0, "B");

        // 8-bit odd parity, 2 stop bits, 0x03: parity bit 1
        sel = 2'd2;
        d8c = 8'h03;
        valid_v[2] = 1'b1;
        run_frame(64'b011000000111, 12, 1'b0, "C");

        // Valid held, Data incrementing every cycle: second accept is 161 edges later
        sel = 2'd3;
        d32 = 32'h11223344;
        valid_v[3] = 1'b1;
        inc_en = 1'b1;
        run_frame(frame32(32'h11223344), 40, 1'b1, "HS0");
        run_frame(frame32(32'h112233E5), 40, 1'b0, "HS1");
        inc_en = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("HS idle ser", 64'(ser_m), 64'd1);
            chk("HS idle ready", 64'(ready_m), 64'd1);
        end

        // Abort during the start bit of byte 2 (cycles 80..83 after accept)
        d32 = 32'hCAFEF00D;
        valid_v[3] = 1'b1;
        @(posedge CLK);
        #1 valid_v[3] = 1'b0;
        repeat (82) @(negedge CLK);
        chk("ABT ser_before", 64'(ser_m), 64'd0);
        chk("ABT busy_before", 64'(busy_m), 64'd1);
        #1 CLR = 1'b0;
        #1;
        chk("ABT ser_now", 64'(ser_m), 64'd1);
        chk("ABT ready_now", 64'(ready_m), 64'd1);
        chk("ABT busy_now", 64'(busy_m), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("ABT hold%0d ser", i), 64'(ser_m), 64'd1);
            chk($sformatf("ABT hold%0d ready", i), 64'(ready_m), 64'd1);
            chk($sformatf("ABT hold%0d busy", i), 64'(busy_m), 64'd0);
            chk($sformatf("ABT hold%0d baud", i), 64'(baud_m), 64'd0);
        end
        CLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("POST idle%0d ser", i), 64'(ser_m), 64'd1);
            chk($sformatf("POST idle%0d busy", i), 64'(busy_m), 64'd0);
        end
        d32 = 32'hDEADBEEF;
        valid_v[3] = 1'b1;
        run_frame(frame32(32'hDEADBEEF), 40, 1'b0, "POST");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised multi-byte UART transmitter: the next generation of the serial transmit path for the BLDC controller. It accepts a DATA_W-bit word over a valid/ready handshake and serialises it as DATA_W/8 back-to-back UART frames, least-significant byte first. Frames have configurable parity and stop-bit count, and a one-cycle baud strobe marks every bit boundary. It sits between the telemetry/command logic and the board TX pin.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8 and at least 8. NBYTES = DATA_W/8.
- BAUD_DIV, 434: system clocks per bit (50 MHz / 115200); must be at least 2.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- CLK  in  1  system clock; all logic on rising edge.
- CLR  in  1  reset, asynchronous assert, active-low; synchronous release is the integrator's job.
- Data  in  DATA_W  word to send; sampled only on accept.
- Valid  in  1  Data is valid.
- Ready  out  1  block can accept a word.
- OUT_ser  out  1  serial line; idle high.
- CLK_Baud  out  1  one-cycle strobe at the end of each transmitted bit.
- Busy  out  1  a word is in flight.

## Operation
- Reset (CLR low) forces, immediately: OUT_ser=1, Ready=1, Busy=0, CLK_Baud=0, FSM=IDLE, counters=0.
- Accept: Valid && Ready at a rising edge.
  - Data is latched into a shift register.
  - Byte index and baud counter are cleared.
  - FSM moves to START.
  - Ready=0 and Busy=1 from that edge.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START on accept.
  - START -> DATA after 1 bit.
  - DATA -> PAR (PARITY!=0) or STOP after 8 bits.
  - PAR -> STOP after 1 bit.
  - STOP -> START (more bytes remain) or IDLE (last byte) after STOP_BITS bits.
- Line levels per state:
  - START: OUT_ser=0.
  - DATA: OUT_ser = current byte bit, LSB first.
  - PAR: even parity = XOR of the 8 data bits; odd parity = its inverse.
  - STOP and IDLE: OUT_ser=1.
- Byte order: byte 0 = Data[7:0] first, byte NBYTES-1 last. Bytes follow with no idle gap between them.
- Bits per byte: B = 10 + (PARITY!=0) + (STOP_BITS-1).
- Handshake rules:
  - Valid while Ready=0 is ignored; no buffering.
  - Changes on Data after accept do not affect the frame in flight.
- Baud counter:
  - Counts 0..BAUD_DIV-1 while not IDLE and wraps.
  - CLK_Baud=1 for exactly the one cycle in which the counter equals BAUD_DIV-1.
  - The counter is held at 0 in IDLE, so bit timing is always phase-aligned to accept.
- Reset mid-word aborts immediately: line returns high, the partial frame is lost, and no recovery frame is sent.

## Timing
- Let t0 = the accept edge.
- OUT_ser is registered. It falls at t0 and each bit lasts exactly BAUD_DIV cycles.
- Bit k of the word stream (k = 0..NBYTES*B-1) occupies cycles [t0 + k*BAUD_DIV, t0 + (k+1)*BAUD_DIV).
- Final stop bit ends at t0 + NBYTES*B*BAUD_DIV. At that edge FSM=IDLE, Ready=1, Busy=0.
- Back-to-back words with Valid held high: the next accept happens one edge later, so there is exactly one idle-high cycle between words.
- CLK_Baud pulses NBYTES*B times per word. The last pulse is in the cycle before Ready rises.
- No combinational path from Valid or Data to any output.

## Structure
- Package uart_pkg holds:
  - the parity enum: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the FSM state typedef: IDLE, START, DATA, PAR, STOP;
  - a parity function: XOR-reduce of a byte.
- Sub-module uart_baud_gen contains the BAUD_DIV counter with enable and the CLK_Baud strobe. It is reused by the planned receiver.
- Elaboration-time checks: DATA_W%8==0, BAUD_DIV>=2, PARITY in 0..2, STOP_BITS in 1..2.

## Test plan
- Reset values: hold CLR low for 5 cycles mid-stream -> OUT_ser=1, Ready=1, Busy=0, CLK_Baud=0 throughout; after release, no transmission until Valid.
- Basic frame, DATA_W=8, BAUD_DIV=4, PARITY=0, STOP_BITS=1, Data=8'h03:
  - OUT_ser sequence per 4 cycles is 0,1,1,0,0,0,0,0,0,1;
  - Ready rises at t0+40;
  - 10 CLK_Baud pulses.
- Multi-byte with even parity, DATA_W=16, BAUD_DIV=4, PARITY=1, Data=16'hA503:
  - byte 0x03 (parity 0) is sent, then byte 0xA5 (data bits 1,0,1,0,0,1,0,1, parity 0);
  - the bytes follow with no gap;
  - Ready rises at t0+88.
- Odd parity and 2 stop bits, DATA_W=8, PARITY=2, STOP_BITS=2, Data=8'h03:
  - parity bit is 1;
  - line high for 8 cycles after the parity bit;
  - Ready rises at t0+48.
- Handshake, DATA_W=32, BAUD_DIV=4:
  - Valid held high with Data incremented every cycle -> each word equals the value present at its accept edge;
  - exactly one idle-high cycle between words;
  - Valid during Busy is ignored.
- Abort: assert CLR in the middle of byte 2 of a 32-bit word -> OUT_ser=1 immediately; after release the next accepted word is transmitted intact from its start bit.
